// File: rtl/i2c_bus_arbiter.sv
// Round-robin front end that shares one I2C master engine between NUM_REQ
// write requesters, with a response timeout and enforced bus-free time.
module i2c_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int BUS_FREE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_err,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data,
  input  logic                 m_done,
  output logic                 busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(BUS_FREE_CYC - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur;
  logic [TIMER_W-1:0] timer;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  int                 cand_i;
  logic [6:0]         win_addr;
  logic [7:0]         win_data;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = NUM_REQ'(1) << i;
  endfunction

  // Search upward from the slot after the last winner, wrapping around.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    cand_i   = 0;
    win_addr = '0;
    win_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = int'(last_grant) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = IDX_W'(cand_i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IDX_W'(k)) begin
        win_addr = req_addr[7*k +: 7];
        win_data = req_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cur        <= '0;
      timer      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      m_start    <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            m_addr    <= win_addr;
            m_data    <= win_data;
            req_ready <= onehot(win);
            cur       <= win;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m_start <= 1'b1;
          timer   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A done pulse on the final timeout cycle still counts as success.
          if (m_done || timer == TO_LAST) begin
            rsp_valid <= onehot(cur);
            rsp_err   <= !m_done;
            state     <= RESP;
          end
        end
        RESP: begin
          last_grant <= cur;
          timer      <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          if (timer == HOLD_LAST) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  a_ready_pulse: assert property (@(posedge clk) disable iff (reset)
    (req_ready != '0) |=> (req_ready == '0));
  a_rsp_pulse: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid != '0) |=> (rsp_valid == '0));
  a_start_pulse: assert property (@(posedge clk) disable iff (reset)
    m_start |=> !m_start);
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(rsp_valid));

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: expected grants and responses are queued
// as stimulus is driven and checked as the DUT produces them.
module tb_i2c_bus_arbiter;
  localparam int NR  = 4;
  localparam int TO  = 16;
  localparam int BF  = 4;
  localparam int GAP = BF + 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [7*NR-1:0] req_addr = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic            rsp_err;
  logic            m_start;
  logic [6:0]      m_addr;
  logic [7:0]      m_data;
  logic            m_done = 1'b0;
  logic            busy;

  i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO), .BUS_FREE_CYC(BF)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_done(m_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; logic [6:0] addr; logic [7:0] data; int gap;} grant_t;
  typedef struct {int idx; logic err; int cyc;} rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  int     dq[$];
  int     grant_cycles[$];
  int     remaining[NR];
  int     cd = -1;
  int     force_done_cyc = -1;
  int     last_rsp_cyc = -1000;
  int     grant_cyc = 0;
  int     cur_idx = 0;
  logic [6:0] cur_addr = '0;
  logic [7:0] cur_data = '0;
  bit     start_pending = 1'b0;
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock of monitoring and driving, evaluated on the falling edge.
  task automatic tick();
    grant_t g;
    rsp_t   r;
    int     d;
    @(negedge clk);
    if (req_ready != '0) begin
      if (gq.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
      else begin
        g = gq.pop_front();
        chk("grant_onehot", 32'(req_ready), 32'(1) << g.idx);
        if (g.gap >= 0) chk("grant_gap", cyc - last_rsp_cyc, g.gap);
        cur_idx = g.idx; cur_addr = g.addr; cur_data = g.data;
        grant_cyc = cyc; start_pending = 1'b1;
        grant_cycles.push_back(cyc);
      end
      for (int i = 0; i < NR; i++)
        if (req_ready[i] && remaining[i] > 0) begin
          remaining[i]--;
          if (remaining[i] == 0) req_valid[i] = 1'b0;
        end
    end
    if (m_start) begin
      if (!start_pending) chk("unexpected_start", 32'(m_start), 0);
      else begin
        start_pending = 1'b0;
        chk("start_latency", cyc - grant_cyc, 1);
        chk("m_addr", 32'(m_addr), 32'(cur_addr));
        chk("m_data", 32'(m_data), 32'(cur_data));
        chk("busy_active", 32'(busy), 1);
        d = (dq.size() != 0) ? dq.pop_front() : -1;
        r.idx = cur_idx;
        r.err = !(d >= 0 && d < TO);
        r.cyc = r.err ? cyc + TO : cyc + d + 1;
        rq.push_back(r);
        cd = d;
      end
    end
    if (rsp_valid != '0) begin
      if (rq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
      else begin
        r = rq.pop_front();
        chk("rsp_onehot", 32'(rsp_valid), 32'(1) << r.idx);
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_time", cyc, r.cyc);
        chk("m_addr_hold", 32'(m_addr), 32'(cur_addr));
      end
      last_rsp_cyc = cyc;
    end else begin
      chk("rsp_err_idle", 32'(rsp_err), 0);
    end
    m_done = 1'b0;
    if (cd == 0) begin
      m_done = 1'b1;
      cd = -1;
    end else if (cd > 0) cd--;
    if (cyc == force_done_cyc) m_done = 1'b1;
  endtask

  task automatic post(input int i, input logic [6:0] a, input logic [7:0] dt, input int n);
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = dt;
    remaining[i] = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_grant(input int i, input logic [6:0] a, input logic [7:0] dt, input int gap);
    grant_t g;
    g.idx = i; g.addr = a; g.data = dt; g.gap = gap;
    gq.push_back(g);
  endtask

  // Wait until all queued work is seen; optionally also until the DUT is idle.
  task automatic wait_q(input string tag, input int budget, input bit need_idle);
    int k = 0;
    while ((gq.size() != 0 || rq.size() != 0 || start_pending || (need_idle && busy)) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, gq.size() + rq.size() + int'(start_pending) + (need_idle ? int'(busy) : 0), 0);
  endtask

  task automatic clear_model();
    gq.delete(); rq.delete(); dq.delete();
    cd = -1; force_done_cyc = -1; start_pending = 1'b0;
    last_rsp_cyc = -1000; m_done = 1'b0; req_valid = '0;
    for (int i = 0; i < NR; i++) remaining[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outs", 32'({req_ready, rsp_valid, rsp_err, m_start, busy, m_addr, m_data}), 0);
    clear_model();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int p;
    #1;
    chk("reset_initial", 32'({req_ready, rsp_valid, rsp_err, m_start, busy, m_addr, m_data}), 0);
    clear_model();
    tick();

    // Test 1: single request from requester 2.
    do_reset();
    grant_cycles.delete();
    p = cyc;
    post(2, 7'h50, 8'hA5, 1);
    expect_grant(2, 7'h50, 8'hA5, -1);
    dq.push_back(12);
    wait_q("t1_drain", 200, 1'b1);
    chk("t1_grant_latency", (grant_cycles.size() > 0) ? grant_cycles[0] - p : -1, 1);
    chk("t1_m_addr_after", 32'(m_addr), 32'h50);

    // Test 2: all requesters continuously valid.
    do_reset();
    for (int i = 0; i < NR; i++) post(i, 7'(7'h10 + i), 8'(8'h30 + i), (i == 0) ? 2 : 1);
    expect_grant(0, 7'h10, 8'h30, -1);
    expect_grant(1, 7'h11, 8'h31, GAP);
    expect_grant(2, 7'h12, 8'h32, GAP);
    expect_grant(3, 7'h13, 8'h33, GAP);
    expect_grant(0, 7'h10, 8'h30, GAP);
    for (int i = 0; i < 5; i++) dq.push_back(10);
    wait_q("t2_drain", 600, 1'b1);

    // Test 3: timeout on requester 0, then requester 2 served after HOLD.
    do_reset();
    post(0, 7'h22, 8'h5A, 1);
    post(2, 7'h33, 8'hC3, 1);
    expect_grant(0, 7'h22, 8'h5A, -1);
    expect_grant(2, 7'h33, 8'hC3, GAP);
    dq.push_back(-1);
    dq.push_back(5);
    wait_q("t3_drain", 300, 1'b1);

    // Test 4: done on the last timeout cycle, then a stray done during HOLD.
    do_reset();
    post(0, 7'h44, 8'h11, 1);
    expect_grant(0, 7'h44, 8'h11, -1);
    dq.push_back(TO - 1);
    wait_q("t4_first", 200, 1'b0);
    force_done_cyc = cyc + 2;
    post(1, 7'h45, 8'h12, 1);
    expect_grant(1, 7'h45, 8'h12, GAP);
    dq.push_back(3);
    wait_q("t4_drain", 200, 1'b1);

    // Test 5: reset while requester 1 is waiting on the master.
    do_reset();
    post(1, 7'h66, 8'h99, 1);
    expect_grant(1, 7'h66, 8'h99, -1);
    dq.push_back(100);
    begin
      int k = 0;
      while ((gq.size() != 0 || start_pending) && k < 50) begin tick(); k++; end
      chk("t5_reach_wait", gq.size() + int'(start_pending), 0);
    end
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1 chk("t5_async_reset", 32'({req_ready, rsp_valid, rsp_err, m_start, busy, m_addr, m_data}), 0);
    clear_model();
    tick();
    post(1, 7'h01, 8'h10, 1);
    post(3, 7'h03, 8'h30, 1);
    expect_grant(1, 7'h01, 8'h10, -1);
    expect_grant(3, 7'h03, 8'h30, GAP);
    dq.push_back(2);
    dq.push_back(2);
    tick();
    reset = 1'b0;
    wait_q("t5_drain", 200, 1'b1);

    // Test 6: requester 3 pulses valid only while the block is in HOLD.
    do_reset();
    post(0, 7'h70, 8'h07, 1);
    expect_grant(0, 7'h70, 8'h07, -1);
    dq.push_back(4);
    wait_q("t6_first", 200, 1'b0);
    tick();
    post(3, 7'h7F, 8'hFF, 0);
    tick();
    tick();
    req_valid[3] = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t6_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
